// File: rtl/alarm_pkg.sv
// Shared alarm state encoding, also used by the display/LED state indicator.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam int SNZ_W = 2;

endpackage

// File: rtl/btn_edge.sv
// Button front-end: two-flop synchronizer followed by a registered rising-edge pulse.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      // p0/p1: metastability guard; p2: previous synced level for edge detect
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
      pulse   <= sync_p1 & ~hist_p2;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: arm/disarm, ring on time match, snooze and off handling.
// Optional BUZZER_PULSE_EN macro gives a 1 s on / 1 s off buzzer instead of a steady tone.
module alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int CNT_W       = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       alarm_btn,
  input  logic       snooze_btn,
  input  logic       off_btn,
  input  logic       alarm_trig,
  output logic       alarm_on,
  output logic       ringing,
  output logic       buzzer,
  output logic [1:0] snooze_cnt
);
  import alarm_pkg::*;

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);
  localparam logic [SNZ_W-1:0] SNZ_MAX     = SNZ_W'(MAX_SNOOZE);

  alarm_state_t     state, state_nxt;
  logic [CNT_W-1:0] sec_cnt, sec_cnt_nxt;
  logic [SNZ_W-1:0] snz_nxt;
  logic             alarm_p, snooze_p, off_p;
  logic             alarm_trig_d, trig_rise;
  logic             buzzer_nxt;

  btn_edge u_alarm_edge  (.clk(clk), .rst_n(rst_n), .btn(alarm_btn),  .pulse(alarm_p));
  btn_edge u_snooze_edge (.clk(clk), .rst_n(rst_n), .btn(snooze_btn), .pulse(snooze_p));
  btn_edge u_off_edge    (.clk(clk), .rst_n(rst_n), .btn(off_btn),    .pulse(off_p));

  // A held time match must not re-ring after off, so only its rising edge counts.
  assign trig_rise = alarm_trig & ~alarm_trig_d;

  always_comb begin
    state_nxt   = state;
    sec_cnt_nxt = sec_cnt;
    snz_nxt     = snooze_cnt;
    case (state)
      IDLE: begin
        if (alarm_p) state_nxt = ARMED;
      end
      ARMED: begin
        if (alarm_p) begin
          state_nxt = IDLE;
          snz_nxt   = '0;
        end else if (trig_rise) begin
          state_nxt   = RINGING;
          sec_cnt_nxt = '0;
          snz_nxt     = '0;
        end
      end
      RINGING: begin
        if (alarm_p) begin
          state_nxt = IDLE;
          snz_nxt   = '0;
        end else if (off_p) begin
          state_nxt = ARMED;
        end else if (snooze_p) begin
          if (snooze_cnt < SNZ_MAX) begin
            state_nxt   = SNOOZE;
            sec_cnt_nxt = '0;
            snz_nxt     = snooze_cnt + 1'b1;
          end else begin
            state_nxt = ARMED;
          end
        end else if (sec_tick) begin
          if (sec_cnt == RING_LAST) begin
            state_nxt   = ARMED;
            sec_cnt_nxt = '0;
          end else begin
            sec_cnt_nxt = sec_cnt + 1'b1;
          end
        end
      end
      SNOOZE: begin
        if (alarm_p) begin
          state_nxt = IDLE;
          snz_nxt   = '0;
        end else if (off_p) begin
          state_nxt = ARMED;
        end else if (sec_tick) begin
          if (sec_cnt == SNOOZE_LAST) begin
            state_nxt   = RINGING;
            sec_cnt_nxt = '0;
          end else begin
            sec_cnt_nxt = sec_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BUZZER_PULSE_EN
  logic beep, beep_nxt;

  // Beep restarts high on every entry to RINGING, then flips once per second.
  always_comb begin
    beep_nxt = beep;
    if (state_nxt == RINGING && state != RINGING)
      beep_nxt = 1'b1;
    else if (state == RINGING && state_nxt == RINGING && sec_tick)
      beep_nxt = ~beep;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beep <= 1'b0;
    else        beep <= beep_nxt;
  end

  assign buzzer_nxt = (state_nxt == RINGING) & beep_nxt;
`else
  assign buzzer_nxt = (state_nxt == RINGING);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sec_cnt      <= '0;
      snooze_cnt   <= '0;
      alarm_trig_d <= 1'b0;
      alarm_on     <= 1'b0;
      ringing      <= 1'b0;
      buzzer       <= 1'b0;
    end else begin
      state        <= state_nxt;
      sec_cnt      <= sec_cnt_nxt;
      snooze_cnt   <= snz_nxt;
      alarm_trig_d <= alarm_trig;
      alarm_on     <= (state_nxt != IDLE);
      ringing      <= (state_nxt == RINGING);
      buzzer       <= buzzer_nxt;
    end
  end

endmodule
